// File: rtl/janus_bus_unit.sv
`default_nettype none
// ============================================================================
// Module      : janus_bus_unit
// Description : N-port memory bus unit. Arbitrates round-robin among the
//               requesters and sequences the MAR-write then RAM-read/write
//               handshake on the external memory control bus. Each phase is
//               protected by an optional timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   req/we/addr/wdata         : per-port request, write enable, address, data
//   ack/err                   : per-port completion / timeout pulses
//   rdata                     : last read data
//   ab/dob/dib                : memory address, write-data and read-data buses
//   mar_wr/ram_wr/ram_oe      : memory strobes
//   mar_wr_ack/ram_wr_ack/
//   ram_oe_ack                : memory acknowledges
//   busy                      : high whenever a transaction is in progress
// ============================================================================
module janus_bus_unit #(
  parameter int PA_DATA_WIDTH = 32,
  parameter int PA_ADDR_WIDTH = 32,
  parameter int PA_PORTS      = 2,
  parameter int PA_TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PA_PORTS-1:0]               req,
  input  logic [PA_PORTS-1:0]               we,
  input  logic [PA_PORTS*PA_ADDR_WIDTH-1:0] addr,
  input  logic [PA_PORTS*PA_DATA_WIDTH-1:0] wdata,
  output logic [PA_PORTS-1:0]               ack,
  output logic [PA_PORTS-1:0]               err,
  output logic [PA_DATA_WIDTH-1:0]          rdata,
  output logic [PA_ADDR_WIDTH-1:0]          ab,
  output logic [PA_DATA_WIDTH-1:0]          dob,
  input  logic [PA_DATA_WIDTH-1:0]          dib,
  output logic                              mar_wr,
  output logic                              ram_wr,
  output logic                              ram_oe,
  input  logic                              mar_wr_ack,
  input  logic                              ram_wr_ack,
  input  logic                              ram_oe_ack,
  output logic                              busy
);

  localparam int PW = (PA_PORTS > 1) ? $clog2(PA_PORTS) : 1;
  localparam int CW = (PA_TIMEOUT > 1) ? $clog2(PA_TIMEOUT + 1) : 1;

  // The phase times out on the cycle the counter would step to PA_TIMEOUT.
  localparam logic [CW-1:0] C_TO_LAST    = CW'((PA_TIMEOUT > 0) ? PA_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] C_LAST_PORT  = PW'(PA_PORTS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAR  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_rr;
  logic [PW-1:0] r_gnt;
  logic          r_we;
  logic [CW-1:0] r_cnt;

  logic          w_found;
  logic [PW-1:0] w_gnt;
  logic          w_timeout;
  logic          w_acc_ack;

  logic [PA_ADDR_WIDTH-1:0] w_addr_arr  [PA_PORTS];
  logic [PA_DATA_WIDTH-1:0] w_wdata_arr [PA_PORTS];

  for (genvar i = 0; i < PA_PORTS; i++) begin : g_unpack
    assign w_addr_arr[i]  = addr[i*PA_ADDR_WIDTH +: PA_ADDR_WIDTH];
    assign w_wdata_arr[i] = wdata[i*PA_DATA_WIDTH +: PA_DATA_WIDTH];
  end

  // Port index (base + k) modulo PA_PORTS.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= PA_PORTS) s = s - PA_PORTS;
    return PW'(s);
  endfunction

  // Round-robin search: first asserted request at or after r_rr.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < PA_PORTS; k++) begin
      if (!w_found && req[wrap_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_gnt   = wrap_idx(r_rr, k);
      end
    end
  end

  assign w_timeout = (PA_TIMEOUT != 0) && (r_cnt == C_TO_LAST);
  assign w_acc_ack = r_we ? ram_wr_ack : ram_oe_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      ack     <= '0;
      err     <= '0;
      rdata   <= '0;
      ab      <= '0;
      dob     <= '0;
      mar_wr  <= 1'b0;
      ram_wr  <= 1'b0;
      ram_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      err <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_we    <= we[w_gnt];
            ab      <= w_addr_arr[w_gnt];
            dob     <= w_wdata_arr[w_gnt];
            r_cnt   <= '0;
            mar_wr  <= 1'b1;
            busy    <= 1'b1;
            r_state <= S_MAR;
          end
        end
        S_MAR: begin
          if (mar_wr_ack) begin
            mar_wr  <= 1'b0;
            r_cnt   <= '0;
            ram_wr  <= r_we;
            ram_oe  <= !r_we;
            r_state <= S_ACC;
          end else if (w_timeout) begin
            mar_wr     <= 1'b0;
            ack[r_gnt] <= 1'b1;
            err[r_gnt] <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACC: begin
          // An ack on the final timeout cycle takes priority over the timeout.
          if (w_acc_ack) begin
            ram_wr     <= 1'b0;
            ram_oe     <= 1'b0;
            if (!r_we) rdata <= dib;
            ack[r_gnt] <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            ram_wr     <= 1'b0;
            ram_oe     <= 1'b0;
            ack[r_gnt] <= 1'b1;
            err[r_gnt] <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_rr    <= (r_gnt == C_LAST_PORT) ? '0 : r_gnt + 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_janus_bus_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_janus_bus_unit
// Description : Directed self-checking bench for janus_bus_unit (4 ports,
//               timeout of 4). Expected completions are queued when a request
//               is driven and compared when the unit acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_janus_bus_unit;

  localparam int NP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP-1:0]  req, we;
  logic [NP*32-1:0] addr, wdata;
  logic [NP-1:0]  ack, err;
  logic [31:0]    rdata, ab, dob, dib;
  logic           mar_wr, ram_wr, ram_oe;
  logic           mar_wr_ack, ram_wr_ack, ram_oe_ack;
  logic           busy;

  // Memory responder controls
  logic tie_high, acc_never;
  int   acc_wait;
  int   mar_cnt = 0, acc_cnt = 0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] rdata;
    logic [31:0] ab;
    logic [31:0] dob;
    int          mar_cyc;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  janus_bus_unit #(
    .PA_DATA_WIDTH(32), .PA_ADDR_WIDTH(32), .PA_PORTS(NP), .PA_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .ab(ab), .dob(dob), .dib(dib),
    .mar_wr(mar_wr), .ram_wr(ram_wr), .ram_oe(ram_oe),
    .mar_wr_ack(mar_wr_ack), .ram_wr_ack(ram_wr_ack), .ram_oe_ack(ram_oe_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Acks rise after a strobe has been high for acc_wait cycles (MAR is zero-wait),
  // or are held high permanently in tie_high mode.
  assign mar_wr_ack = tie_high | mar_wr;
  assign ram_wr_ack = tie_high | (ram_wr && !acc_never && acc_cnt >= acc_wait);
  assign ram_oe_ack = tie_high | (ram_oe && !acc_never && acc_cnt >= acc_wait);

  always @(posedge clk) begin
    mar_cnt <= mar_wr ? mar_cnt + 1 : 0;
    acc_cnt <= (ram_wr | ram_oe) ? acc_cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a request, follow the transaction to its ack, compare with the
  // head of the scoreboard. keep=0 drops req after the grant cycle.
  task automatic run_txn(input string tag, input logic [3:0] rq, input bit keep);
    exp_t e;
    int mar_c = 0, acc_c = 0, viol = 0, ack_n = 0;
    bit seen = 0;
    logic [3:0]  a_ack = '0, a_err = '0;
    logic [31:0] a_rd = '0, a_ab = '0, a_dob = '0;
    req = rq;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (!keep) req = '0;
      if (mar_wr) mar_c++;
      if (ram_wr | ram_oe) acc_c++;
      if (int'(mar_wr) + int'(ram_wr) + int'(ram_oe) > 1) viol++;
      if (|ack) begin
        seen  = 1;
        ack_n = n;
        a_ack = ack; a_err = err; a_rd = rdata; a_ab = ab; a_dob = dob;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    chk({tag, "_ack"},   32'(a_ack), 32'(e.ack));
    chk({tag, "_err"},   32'(a_err), 32'(e.err));
    chk({tag, "_rdata"}, a_rd, e.rdata);
    chk({tag, "_ab"},    a_ab, e.ab);
    chk({tag, "_dob"},   a_dob, e.dob);
    chk({tag, "_marcyc"}, 32'(mar_c), 32'(e.mar_cyc));
    chk({tag, "_acccyc"}, 32'(acc_c), 32'(e.acc_cyc));
    chk({tag, "_latency"}, 32'(ack_n), 32'(e.mar_cyc + e.acc_cyc + 1));
    chk({tag, "_onestrobe"}, 32'(viol), 32'd0);
    @(negedge clk);
    chk({tag, "_ackonce"}, 32'(ack), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit oe_seen;
    rst = 1'b1; req = '0; we = '0; dib = '0;
    tie_high = 1'b0; acc_never = 1'b0; acc_wait = 0;
    addr  = {32'h0000_03C0, 32'h0000_0300, 32'h0000_0204, 32'h0000_0100};
    wdata = {32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0000_0000};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ab",    ab, 32'd0);
    chk("rst_dob",   dob, 32'd0);
    chk("rst_strb_busy", 32'({mar_wr, ram_wr, ram_oe, busy}), 32'd0);

    // Zero-wait load on port 0, acks tied high
    tie_high = 1'b1; dib = 32'hDEAD_BEEF;
    sb.push_back('{4'b0001, 4'b0000, 32'hDEAD_BEEF, 32'h100, 32'h0, 1, 1});
    run_txn("load0", 4'b0001, 1'b0);

    // Store on port 1 with 3 wait cycles
    tie_high = 1'b0; acc_wait = 3; we = 4'b0010; dib = 32'h7777_7777;
    sb.push_back('{4'b0010, 4'b0000, 32'hDEAD_BEEF, 32'h204, 32'h1234_5678, 1, 4});
    run_txn("store1", 4'b0010, 1'b0);
    we = '0;

    // Timeout on port 2: read data bus must not be captured
    acc_never = 1'b1; dib = 32'h1111_1111;
    sb.push_back('{4'b0100, 4'b0100, 32'hDEAD_BEEF, 32'h300, 32'hA5A5_A5A5, 1, 4});
    run_txn("tmo2", 4'b0100, 1'b0);

    // Ack on the final timeout cycle on port 3: ack wins, no error
    acc_never = 1'b0; acc_wait = 3; dib = 32'h0BAD_F00D;
    sb.push_back('{4'b1000, 4'b0000, 32'h0BAD_F00D, 32'h3C0, 32'h5A5A_5A5A, 1, 4});
    run_txn("lastack3", 4'b1000, 1'b0);

    // Round-robin from a fresh reset with all requests held
    do_reset();
    tie_high = 1'b1; dib = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      int p;
      p = i % NP;
      sb.push_back('{4'(1 << p), 4'b0000, 32'hCAFE_F00D,
                     addr[p*32 +: 32], wdata[p*32 +: 32], 1, 1});
      run_txn($sformatf("rr%0d", i), 4'b1111, (i != 4));
    end

    // Port 2 completes so the pointer moves on to 3
    sb.push_back('{4'b0100, 4'b0000, 32'hCAFE_F00D, 32'h300, 32'hA5A5_A5A5, 1, 1});
    run_txn("pre2", 4'b0100, 1'b0);

    // Reset while ram_oe is high on a port 3 load
    tie_high = 1'b0; acc_never = 1'b1;
    req = 4'b1000;
    oe_seen = 0;
    for (int n = 0; n < 20 && !oe_seen; n++) begin
      @(negedge clk);
      if (ram_oe) oe_seen = 1;
    end
    req = '0;
    chk("mid_oe_seen", 32'(oe_seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_strb_busy", 32'({mar_wr, ram_wr, ram_oe, busy}), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    acc_never = 1'b0;
    @(negedge clk);
    chk("mid_noack", 32'(ack), 32'd0);

    // Pointer back at 0: port 1 must win over port 3
    tie_high = 1'b1; dib = 32'h600D_600D;
    sb.push_back('{4'b0010, 4'b0000, 32'h600D_600D, 32'h204, 32'h1234_5678, 1, 1});
    run_txn("postrst", 4'b1010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
